pulse_debounce_edge: RTL and testbench

Upstream conditioner for the team's pulse counter. It takes a raw asynchronous input (push-button or external event line) and synchronises it into clk. It debounces the input with a stability counter and FSM. It emits a clean single-cycle pulse on the selected edge, which drives the counter's pulse input directly.

---
 rtl/pulse_debounce_edge.sv | 122 ++++++++++++
 tb/tb_pulse_debounce_edge.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_debounce_edge.sv
// Synchronises and debounces a raw asynchronous input, emitting a one-cycle pulse on the selected accepted edge.
// Optional build macro GLITCH_COUNT_EN adds a saturating rejected-glitch counter (glitch_clr / glitch_cnt).
module pulse_debounce_edge #(
  parameter  int SYNC_STAGES     = 2,
  parameter  int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw_in,
  input  logic       enable,
  input  logic [1:0] edge_sel,
`ifdef GLITCH_COUNT_EN
  input  logic       glitch_clr,
  output logic [7:0] glitch_cnt,
`endif
  output logic       level,
  output logic       pulse,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    IDLE_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s_in;
  state_t                 state, state_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic                   acc_rise, acc_fall;
  logic                   pulse_nx;

  // Stage p0: synchroniser chain, only its last flop is seen by the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_p0 <= '0;
    else        sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw_in};
  end

  assign s_in = sync_p0[SYNC_STAGES-1];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    acc_rise = 1'b0;
    acc_fall = 1'b0;
    unique case (state)
      IDLE_LOW: if (s_in) begin
        state_nx = CHECK_HIGH;
        cnt_nx   = CNT_W'(1);
      end
      CHECK_HIGH: if (!s_in) begin
        state_nx = IDLE_LOW;
        cnt_nx   = '0;
      end else if (cnt == CNT_LAST) begin
        state_nx = IDLE_HIGH;
        cnt_nx   = '0;
        acc_rise = 1'b1;
      end else begin
        cnt_nx = cnt + CNT_W'(1);
      end
      IDLE_HIGH: if (!s_in) begin
        state_nx = CHECK_LOW;
        cnt_nx   = CNT_W'(1);
      end
      CHECK_LOW: if (s_in) begin
        state_nx = IDLE_HIGH;
        cnt_nx   = '0;
      end else if (cnt == CNT_LAST) begin
        state_nx = IDLE_LOW;
        cnt_nx   = '0;
        acc_fall = 1'b1;
      end else begin
        cnt_nx = cnt + CNT_W'(1);
      end
      default: begin
        state_nx = IDLE_LOW;
        cnt_nx   = '0;
      end
    endcase
  end

  // Gate and edge selection are only consulted in the accept cycle
  assign pulse_nx = enable &&
                    ((acc_rise && (edge_sel == 2'b00 || edge_sel == 2'b10)) ||
                     (acc_fall && (edge_sel == 2'b01 || edge_sel == 2'b10)));

  // Stage p1: FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pulse <= pulse_nx;
      busy  <= (state_nx == CHECK_HIGH) || (state_nx == CHECK_LOW);
      if (acc_rise)      level <= 1'b1;
      else if (acc_fall) level <= 1'b0;
    end
  end

`ifdef GLITCH_COUNT_EN
  logic reject;

  assign reject = ((state == CHECK_HIGH) && !s_in) || ((state == CHECK_LOW) && s_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             glitch_cnt <= 8'd0;
    else if (glitch_clr)                    glitch_cnt <= 8'd0;
    else if (reject && glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_pulse_debounce_edge.sv
// Randomised and directed bench for pulse_debounce_edge against a run-length debounce model.
// Also exercises the GLITCH_COUNT_EN build when that macro is defined.
module tb_pulse_debounce_edge;

  localparam int S = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       raw_in = 1'b0;
  logic       enable = 1'b1;
  logic [1:0] edge_sel = 2'b00;
  logic       level, pulse, busy;
`ifdef GLITCH_COUNT_EN
  logic       glitch_clr = 1'b0;
  logic [7:0] glitch_cnt;
`endif

  int nvec = 0;
  int nerr = 0;
  int npulse = 0;

  pulse_debounce_edge #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .raw_in(raw_in),
    .enable(enable),
    .edge_sel(edge_sel),
`ifdef GLITCH_COUNT_EN
    .glitch_clr(glitch_clr),
    .glitch_cnt(glitch_cnt),
`endif
    .level(level),
    .pulse(pulse),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a sample of raw_in reaches the debouncer S edges after it is taken;
  // the level flips once D consecutive delivered samples disagree with it.
  logic m_level, m_pulse, m_busy;
  int   m_run;
  int   m_gc;
  logic sq[$];

  task automatic model_reset();
    sq.delete();
    for (int i = 0; i < S; i++) sq.push_back(1'b0);
    m_level = 1'b0; m_pulse = 1'b0; m_busy = 1'b0; m_run = 0; m_gc = 0;
  endtask

  task automatic model_step();
    logic s;
    logic acc, rej;
    s = sq.pop_front();
    sq.push_back(raw_in);
    acc = 1'b0; rej = 1'b0;
    if (s != m_level) begin
      m_run++;
      if (m_run == D) begin
        m_level = s;
        m_run = 0;
        acc = 1'b1;
      end
    end else begin
      rej = (m_run > 0);
      m_run = 0;
    end
    m_pulse = acc && enable &&
              (m_level ? (edge_sel == 2'd0 || edge_sel == 2'd2)
                       : (edge_sel == 2'd1 || edge_sel == 2'd2));
    m_busy = (m_run > 0);
`ifdef GLITCH_COUNT_EN
    if (glitch_clr) m_gc = 0;
    else if (rej && m_gc < 255) m_gc++;
`endif
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Per-cycle comparison on the inactive edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("level", int'(level), int'(m_level));
      chk("pulse", int'(pulse), int'(m_pulse));
      chk("busy",  int'(busy),  int'(m_busy));
`ifdef GLITCH_COUNT_EN
      chk("glitch_cnt", int'(glitch_cnt), m_gc);
`endif
      if (pulse) npulse++;
    end
  end

  task automatic hold(input logic r, input int n);
    raw_in = r;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #12;
    chk("reset_level", int'(level), 0);
    chk("reset_pulse", int'(pulse), 0);
    chk("reset_busy",  int'(busy),  0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    hold(1'b0, 5);

    // Clean rising edge, then clean falling edge, with literal timing
    enable = 1'b1; edge_sel = 2'b00;
    raw_in = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #2;
      chk("rise_level", int'(level), (k >= 6) ? 1 : 0);
      chk("rise_pulse", int'(pulse), (k == 6) ? 1 : 0);
      chk("rise_busy",  int'(busy),  (k >= 3 && k <= 5) ? 1 : 0);
    end
    raw_in = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #2;
      chk("fall_level", int'(level), (k >= 6) ? 0 : 1);
      chk("fall_pulse", int'(pulse), 0);
    end

    // Short glitch is rejected
    npulse = 0;
    hold(1'b1, 2);
    hold(1'b0, 10);
    chk("glitch_pulses", npulse, 0);
    chk("glitch_level", int'(level), 0);

    // Both edges, then no edges
    npulse = 0; edge_sel = 2'b10;
    hold(1'b1, 10); hold(1'b0, 10);
    chk("both_pulses", npulse, 2);
    npulse = 0; edge_sel = 2'b11;
    hold(1'b1, 10);
    chk("none_level_hi", int'(level), 1);
    hold(1'b0, 10);
    chk("none_pulses", npulse, 0);
    chk("none_level_lo", int'(level), 0);

    // Gated rising edge, enable raised afterwards
    npulse = 0; edge_sel = 2'b00; enable = 1'b0;
    hold(1'b1, 10);
    chk("gated_level", int'(level), 1);
    enable = 1'b1;
    hold(1'b1, 10);
    chk("gated_pulses", npulse, 0);
    hold(1'b0, 10);

    // Input high across reset release, then reset in the middle of a falling check
    rst_n = 1'b0; raw_in = 1'b1;
    hold(1'b1, 3);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #2;
      chk("rel_level", int'(level), (k >= 6) ? 1 : 0);
      chk("rel_pulse", int'(pulse), (k == 6) ? 1 : 0);
    end
    hold(1'b0, 4);
    chk("midchk_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_level", int'(level), 0);
    chk("abort_busy",  int'(busy),  0);
    chk("abort_pulse", int'(pulse), 0);
    hold(1'b0, 3);
    rst_n = 1'b1;
    hold(1'b0, 5);

`ifdef GLITCH_COUNT_EN
    glitch_clr = 1'b1; hold(1'b0, 1); glitch_clr = 1'b0;
    for (int g = 0; g < 260; g++) begin
      hold(1'b1, 2);
      hold(1'b0, 3);
    end
    chk("glitch_sat", int'(glitch_cnt), 255);
    hold(1'b1, 2);
    glitch_clr = 1'b1;
    hold(1'b0, 4);
    glitch_clr = 1'b0;
    chk("glitch_clr", int'(glitch_cnt), 0);
`endif

    // Randomised runs with random gating and edge selection
    for (int i = 0; i < 300; i++) begin
      enable   = ($urandom_range(0, 3) != 0);
      edge_sel = 2'($urandom_range(0, 3));
`ifdef GLITCH_COUNT_EN
      glitch_clr = ($urandom_range(0, 15) == 0);
`endif
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 9));
    end
    hold(1'b0, 12);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
